// File: rtl/iq_dsp_pkg.sv
// Shared constants for the baseband I/Q DSP chain.
// Holds the CIC order, the default widths and the internal-width helper.
package iq_dsp_pkg;

    localparam int CIC_ORDER  = 3;
    localparam int DEF_IW     = 16;
    localparam int DEF_OW     = 16;
    localparam int DEF_R_LOG2 = 3;

    // Width that holds the full R^N growth, so modular wrap inside the integrators cancels in the combs.
    function automatic int cic_wi(input int iw, input int r_log2);
        return iw + CIC_ORDER * r_log2;
    endfunction

endpackage

// File: rtl/cic_lane.sv
// One channel of the third-order CIC: pipelined integrators, comb chain and output register.
// Decimation timing (in_valid / dec_stb) comes from the top so both lanes stay aligned.
module cic_lane
    import iq_dsp_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int OW     = DEF_OW,
    parameter int R_LOG2 = DEF_R_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 dec_stb,
    input  logic signed [IW-1:0] x,
    output logic signed [OW-1:0] y
);

    localparam int WI = cic_wi(IW, R_LOG2);
    localparam int SH = CIC_ORDER * R_LOG2;

    logic signed [WI-1:0] r_s1, r_s2, r_s3;
    logic signed [WI-1:0] r_z1, r_z2, r_z3;
    logic signed [OW-1:0] r_y;

    logic signed [WI-1:0] w_x;
    logic signed [WI-1:0] w_d1, w_d2, w_d3;
    logic signed [OW-1:0] w_y;

    assign w_x  = {{(WI-IW){x[IW-1]}}, x};
    assign w_d1 = r_s3 - r_z1;
    assign w_d2 = w_d1 - r_z2;
    assign w_d3 = w_d2 - r_z3;
    // Divide by R^3 with floor rounding; the result always fits OW bits.
    assign w_y  = OW'(w_d3 >>> SH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
            r_z1 <= '0;
            r_z2 <= '0;
            r_z3 <= '0;
            r_y  <= '0;
        end else begin
            if (in_valid) begin
                r_s1 <= r_s1 + w_x;
                r_s2 <= r_s2 + r_s1;
                r_s3 <= r_s3 + r_s2;
            end
            if (dec_stb) begin
                r_z1 <= r_s3;
                r_z2 <= w_d1;
                r_z3 <= w_d2;
                r_y  <= w_y;
            end
        end
    end

    assign y = r_y;

endmodule

// File: rtl/iq_cic_decim.sv
// Dual-channel I/Q CIC decimator by 2^R_LOG2 with unity DC gain.
// One shared decimation counter drives both lanes so I and Q can never drift apart.
module iq_cic_decim
    import iq_dsp_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int OW     = DEF_OW,
    parameter int R_LOG2 = DEF_R_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] i,
    input  logic signed [IW-1:0] q,
    output logic signed [OW-1:0] io,
    output logic signed [OW-1:0] qo,
    output logic                 out_valid
);

    localparam logic [R_LOG2-1:0] CNT_ONE = R_LOG2'(1);
    localparam logic [R_LOG2-1:0] CNT_MAX = '1;

    logic [R_LOG2-1:0] r_cnt;
    logic              r_dec_stb;
    logic              r_out_valid;

    // R is a power of two, so the counter wraps R-1 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dec_stb   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            r_dec_stb   <= in_valid && (r_cnt == CNT_MAX);
            r_out_valid <= r_dec_stb;
        end
    end

    assign out_valid = r_out_valid;

    cic_lane #(.IW(IW), .OW(OW), .R_LOG2(R_LOG2)) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .dec_stb  (r_dec_stb),
        .x        (i),
        .y        (io)
    );

    cic_lane #(.IW(IW), .OW(OW), .R_LOG2(R_LOG2)) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .dec_stb  (r_dec_stb),
        .x        (q),
        .y        (qo)
    );

endmodule

// File: tb/tb_iq_cic_decim.sv
// Scoreboarded bench for iq_cic_decim at R_LOG2 = 1, 3 and 6 driven by one shared stimulus.
// Reference: direct FIR with the boxcar^3 kernel (plus 2-sample pipeline delay) over accepted samples.
module tb_iq_cic_decim;

    localparam int NCFG = 3;
    localparam int RL [NCFG] = '{1, 3, 6};

    typedef struct {
        int                 cyc;
        logic signed [15:0] io;
        logic signed [15:0] qo;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] i = '0;
    logic signed [15:0] q = '0;
    logic signed [15:0] io_w [NCFG];
    logic signed [15:0] qo_w [NCFG];
    logic               ov_w [NCFG];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int R_L = RL[g];
        localparam int R   = 1 << R_L;

        longint             coef [3*R-2];
        longint             hi [$];
        longint             hq [$];
        exp_t               sb [$];
        logic signed [15:0] last_i = '0;
        logic signed [15:0] last_q = '0;

        iq_cic_decim #(.IW(16), .OW(16), .R_LOG2(R_L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .i         (i),
            .q         (q),
            .io        (io_w[g]),
            .qo        (qo_w[g]),
            .out_valid (ov_w[g])
        );

        initial begin
            for (int m = 0; m < 3*R-2; m++) coef[m] = 0;
            for (int a = 0; a < R; a++)
                for (int b = 0; b < R; b++)
                    for (int c = 0; c < R; c++)
                        coef[a+b+c]++;
        end

        always @(posedge clk) begin : model
            longint ai, aq;
            int     k;
            exp_t   e;
            if (rst) begin
                hi.delete();
                hq.delete();
                sb.delete();
                last_i = '0;
                last_q = '0;
            end else if (in_valid) begin
                hi.push_back(longint'(i));
                hq.push_back(longint'(q));
                if (hi.size() % R == 0) begin
                    k  = hi.size() - 1;
                    ai = 0;
                    aq = 0;
                    for (int m = 0; m < 3*R-2; m++) begin
                        if (k - 2 - m >= 0) begin
                            ai += coef[m] * hi[k-2-m];
                            aq += coef[m] * hq[k-2-m];
                        end
                    end
                    e.cyc = cyc + 2;
                    e.io  = 16'(ai >>> (3*R_L));
                    e.qo  = 16'(aq >>> (3*R_L));
                    sb.push_back(e);
                end
            end
        end

        always @(negedge clk) begin : monitor
            logic ev;
            exp_t e;
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            ev = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk($sformatf("r%0d_vld", R_L), ov_w[g], ev);
            if (ev) begin
                e = sb.pop_front();
                chk($sformatf("r%0d_io", R_L), io_w[g], e.io);
                chk($sformatf("r%0d_qo", R_L), qo_w[g], e.qo);
                last_i = e.io;
                last_q = e.qo;
            end else begin
                chk($sformatf("r%0d_hold_i", R_L), io_w[g], last_i);
                chk($sformatf("r%0d_hold_q", R_L), qo_w[g], last_q);
            end
        end
    end

    task automatic drive(input logic v, input logic signed [15:0] a, input logic signed [15:0] b);
        in_valid = v;
        i = a;
        q = b;
        @(posedge clk);
        #1;
    endtask

    // Reset with a live sample on the bus: the sample must be discarded.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 16'sd12345, -16'sd12345);
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            chk("rst_io", io_w[g], 0);
            chk("rst_qo", qo_w[g], 0);
            chk("rst_vld", ov_w[g], 0);
        end
    endtask

    initial begin
        logic signed [15:0] tone [4];
        tone[0] = 16'sd16000;
        tone[1] = 16'sd0;
        tone[2] = -16'sd16000;
        tone[3] = 16'sd0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_io", io_w[1], 0);
        chk("init_vld", ov_w[1], 0);

        // DC 1000 / -1000
        repeat (100) drive(1'b1, 16'sd1000, -16'sd1000);
        chk("dc_io", io_w[1], 1000);
        chk("dc_qo", qo_w[1], -1000);

        // full scale, integrators wrap internally
        do_reset();
        repeat (300) drive(1'b1, 16'sd32767, -16'sd32768);
        for (int g = 0; g < NCFG; g++) begin
            chk("fs_io", io_w[g], 32767);
            chk("fs_qo", qo_w[g], -32768);
        end

        // residual fs/4 tone on I
        do_reset();
        for (int n = 0; n < 200; n++) drive(1'b1, tone[n%4], 16'sd0);
        chk("tone_io_small", (io_w[1] >= -1 && io_w[1] <= 1), 1);
        chk("tone_qo", qo_w[1], 0);

        // half-rate in_valid
        do_reset();
        for (int n = 0; n < 200; n++) drive(n % 2 == 0, 16'sd500, 16'sd0);
        chk("half_io", io_w[1], 500);

        // reset on the dec_stb cycle kills the pending output
        do_reset();
        repeat (8) drive(1'b1, 16'sd700, -16'sd700);
        rst = 1'b1;
        drive(1'b0, 16'sd700, -16'sd700);
        rst = 1'b0;
        @(negedge clk);
        chk("rstpend_vld", ov_w[1], 0);
        chk("rstpend_io", io_w[1], 0);
        chk("rstpend_qo", qo_w[1], 0);
        repeat (40) drive(1'b1, 16'sd700, -16'sd700);

        // random stream with random gaps
        do_reset();
        for (int n = 0; n < 10000; n++)
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
        repeat (20) drive(1'b0, 16'sd0, 16'sd0);
        for (int g = 0; g < NCFG; g++) chk("drain_vld", ov_w[g], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
